div16s8u: RTL

DIV16S8U -- requirements
Module: div16s8u

---
 rtl/div16s8u_if.sv | 31 +++
 rtl/div16s8u.sv | 113 +++++++++++
 2 files changed

// File: rtl/div16s8u_if.sv
// div16s8u_if: request/result bundle for the 16-bit signed by 8-bit unsigned divider.
// Ports: i_start/i_a/i_b are driven by the master; o_busy/o_done/o_q/o_r (and o_dz
// when DIV_ZERO_CHK_EN is defined) are driven by the divider through the slave modport.
interface div16s8u_if;
  logic        i_start;
  logic [15:0] i_a;
  logic [7:0]  i_b;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_q;
  logic [8:0]  o_r;
`ifdef DIV_ZERO_CHK_EN
  logic        o_dz;
`endif

  modport master (
    output i_start, i_a, i_b,
`ifdef DIV_ZERO_CHK_EN
    input  o_dz,
`endif
    input  o_busy, o_done, o_q, o_r
  );

  modport slave (
    input  i_start, i_a, i_b,
`ifdef DIV_ZERO_CHK_EN
    output o_dz,
`endif
    output o_busy, o_done, o_q, o_r
  );
endinterface

// File: rtl/div16s8u.sv
// div16s8u: sequential 16-bit signed / 8-bit unsigned divider, truncating toward zero.
// Latency: start accepted at E0, o_done high for one cycle after E17, next start at E19.
// Backpressure: none; i_start is ignored while o_busy is high.
// Ports: clk, rst_n (async active-low), bus (slave modport of div16s8u_if):
//   i_start/i_a/i_b request, o_busy/o_done status, o_q quotient, o_r remainder,
//   o_dz divide-by-zero flag (only when DIV_ZERO_CHK_EN is defined).
// Optional feature macro: DIV_ZERO_CHK_EN.
module div16s8u (
  input  logic        clk,
  input  logic        rst_n,
  div16s8u_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_mag;   // |a| shifts out MSB-first while quotient bits shift in at the LSB
  logic [7:0]  r_rem;   // partial remainder, always < b so 8 bits suffice
  logic [7:0]  r_b;
  logic        r_neg;
  logic [15:0] r_q;
  logic [8:0]  r_r;
`ifdef DIV_ZERO_CHK_EN
  logic        r_dz;
`endif

  logic [8:0]  w_trial;
  logic [9:0]  w_diff;
  logic        w_qbit;
  logic [15:0] w_a_mag;

  // Magnitude of a as 16-bit unsigned; -32768 maps to 0x8000 without loss.
  assign w_a_mag = bus.i_a[15] ? (~bus.i_a + 16'd1) : bus.i_a;

  // One restoring step: bring down the next dividend bit and try subtracting b.
  assign w_trial = {r_rem, r_mag[15]};
  assign w_diff  = {1'b0, w_trial} - {2'b00, r_b};
  assign w_qbit  = ~w_diff[9];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_mag   <= 16'd0;
      r_rem   <= 8'd0;
      r_b     <= 8'd0;
      r_neg   <= 1'b0;
      r_q     <= 16'd0;
      r_r     <= 9'd0;
`ifdef DIV_ZERO_CHK_EN
      r_dz    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_mag   <= w_a_mag;
            r_neg   <= bus.i_a[15];
            r_b     <= bus.i_b;
            r_rem   <= 8'd0;
            r_cnt   <= 4'd0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_qbit ? w_diff[7:0] : w_trial[7:0];
          r_mag <= {r_mag[14:0], w_qbit};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state <= SIGN;
          end
        end
        SIGN: begin
`ifdef DIV_ZERO_CHK_EN
          if (r_b == 8'd0) begin
            // Saturate toward the sign of a; remainder is meaningless so force 0.
            r_q  <= r_neg ? 16'h8000 : 16'h7FFF;
            r_r  <= 9'd0;
            r_dz <= 1'b1;
          end else begin
            r_q  <= r_neg ? (~r_mag + 16'd1) : r_mag;
            r_r  <= r_neg ? (~{1'b0, r_rem} + 9'd1) : {1'b0, r_rem};
            r_dz <= 1'b0;
          end
`else
          r_q <= r_neg ? (~r_mag + 16'd1) : r_mag;
          r_r <= r_neg ? (~{1'b0, r_rem} + 9'd1) : {1'b0, r_rem};
`endif
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy = (r_state != IDLE);
  assign bus.o_done = (r_state == DONE);
  assign bus.o_q    = r_q;
  assign bus.o_r    = r_r;
`ifdef DIV_ZERO_CHK_EN
  assign bus.o_dz   = r_dz;
`endif

endmodule
